// File: rtl/switch_allocator.sv
// switch_allocator
//   Switch allocator and output-credit tracker for the 5-port wormhole router.
//   Each input shows one head-of-line flit. Each output picks a winner by
//   round robin among head flits. A multi-flit packet then keeps the output
//   until its tail flit has passed. A flit is granted only when the downstream
//   buffer has a free credit. Grants, crossbar valids and selects come from
//   combinational logic, so an input is popped in the same cycle it is granted.
//
// Ports
//   i_clk          clock
//   i_rst          synchronous active-high reset
//   i_req_valid    [PORT_NUM]          input i has a head-of-line flit
//   i_req_dest     [PORT_NUM*PORT_W]   destination of input i, slice i
//   i_req_head     [PORT_NUM]          flit is a head flit
//   i_req_tail     [PORT_NUM]          flit is a tail flit (head+tail = single flit)
//   i_credit_ret   [PORT_NUM]          downstream of output o freed one slot
//   o_grant        [PORT_NUM]          input i traverses / pops this cycle
//   o_xbar_valid   [PORT_NUM]          output o carries a flit this cycle
//   o_xbar_sel     [PORT_NUM*PORT_W]   source input for output o, 0 when idle
//   o_credit_cnt   [PORT_NUM*CRED_W]   current credits per output
//   o_err          sticky protocol-error flag
module switch_allocator #(
  parameter  int PORT_NUM   = 5,
  parameter  int CREDIT_MAX = 4,
  localparam int PORT_W     = $clog2(PORT_NUM),
  localparam int CRED_W     = $clog2(CREDIT_MAX + 1)
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [PORT_NUM-1:0]        i_req_valid,
  input  logic [PORT_NUM*PORT_W-1:0] i_req_dest,
  input  logic [PORT_NUM-1:0]        i_req_head,
  input  logic [PORT_NUM-1:0]        i_req_tail,
  input  logic [PORT_NUM-1:0]        i_credit_ret,
  output logic [PORT_NUM-1:0]        o_grant,
  output logic [PORT_NUM-1:0]        o_xbar_valid,
  output logic [PORT_NUM*PORT_W-1:0] o_xbar_sel,
  output logic [PORT_NUM*CRED_W-1:0] o_credit_cnt,
  output logic                       o_err
);

  // Per-output registered state
  logic              r_lock   [PORT_NUM];
  logic [PORT_W-1:0] r_owner  [PORT_NUM];
  logic [PORT_W-1:0] r_rr_ptr [PORT_NUM];
  logic [CRED_W-1:0] r_credit [PORT_NUM];
  logic              r_err;

  // Request decode
  logic [PORT_W-1:0]   w_dest   [PORT_NUM];
  logic [PORT_NUM-1:0] w_dest_ok;
  logic [PORT_NUM-1:0] w_req_to [PORT_NUM];   // w_req_to[o][i]: input i wants output o

  // Arbitration result per output
  logic [PORT_NUM-1:0] w_out_vld;
  logic [PORT_W-1:0]   w_out_src [PORT_NUM];
  logic [PORT_NUM-1:0] w_grant;

  // Error sources
  logic w_err_dest;
  logic w_err_body;
  logic w_err_ovf;
  logic w_err_any;

  // (base + k) mod PORT_NUM for base < PORT_NUM and 0 <= k < PORT_NUM.
  function automatic logic [PORT_W-1:0] wrap_idx(input logic [PORT_W-1:0] base,
                                                 input int k);
    int s;
    s = int'(base) + k;
    if (s >= PORT_NUM) s = s - PORT_NUM;
    return PORT_W'(s);
  endfunction

  always_comb begin
    for (int i = 0; i < PORT_NUM; i++) begin
      w_dest[i]    = i_req_dest[i*PORT_W +: PORT_W];
      w_dest_ok[i] = int'(w_dest[i]) < PORT_NUM;
    end
    for (int o = 0; o < PORT_NUM; o++) begin
      w_req_to[o] = '0;
      for (int i = 0; i < PORT_NUM; i++) begin
        w_req_to[o][i] = i_req_valid[i] && w_dest_ok[i] && (int'(w_dest[i]) == o);
      end
    end
  end

  // Per-output arbitration. A locked output serves only its owner; a free
  // output scans head flits upward from its round-robin pointer. With no
  // credit nothing is granted, so the pointer also stays put.
  always_comb begin
    for (int o = 0; o < PORT_NUM; o++) begin
      w_out_vld[o] = 1'b0;
      w_out_src[o] = '0;
      if (r_credit[o] != '0) begin
        if (r_lock[o]) begin
          if (w_req_to[o][r_owner[o]]) begin
            w_out_vld[o] = 1'b1;
            w_out_src[o] = r_owner[o];
          end
        end else begin
          for (int k = 0; k < PORT_NUM; k++) begin
            if (!w_out_vld[o] && w_req_to[o][wrap_idx(r_rr_ptr[o], k)]
                && i_req_head[wrap_idx(r_rr_ptr[o], k)]) begin
              w_out_vld[o] = 1'b1;
              w_out_src[o] = wrap_idx(r_rr_ptr[o], k);
            end
          end
        end
      end
    end
  end

  // Each input names one destination, so at most one output selects it.
  always_comb begin
    w_grant = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      if (w_out_vld[o]) w_grant[w_out_src[o]] = 1'b1;
    end
  end

  always_comb begin
    w_err_dest = |(i_req_valid & ~w_dest_ok);
    w_err_body = 1'b0;
    w_err_ovf  = 1'b0;
    for (int o = 0; o < PORT_NUM; o++) begin
      if (!r_lock[o] && |(w_req_to[o] & ~i_req_head)) w_err_body = 1'b1;
      if (i_credit_ret[o] && !w_out_vld[o] && (r_credit[o] == CRED_W'(CREDIT_MAX)))
        w_err_ovf = 1'b1;
    end
    w_err_any = w_err_dest | w_err_body | w_err_ovf;
  end

  // Outputs are held quiet while reset is asserted.
  always_comb begin
    o_grant      = i_rst ? '0 : w_grant;
    o_xbar_valid = i_rst ? '0 : w_out_vld;
    o_xbar_sel   = '0;
    o_credit_cnt = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      if (!i_rst && w_out_vld[o]) o_xbar_sel[o*PORT_W +: PORT_W] = w_out_src[o];
      o_credit_cnt[o*CRED_W +: CRED_W] = r_credit[o];
    end
    o_err = r_err;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int o = 0; o < PORT_NUM; o++) begin
        r_lock[o]   <= 1'b0;
        r_owner[o]  <= '0;
        r_rr_ptr[o] <= '0;
        r_credit[o] <= CRED_W'(CREDIT_MAX);
      end
      r_err <= 1'b0;
    end else begin
      for (int o = 0; o < PORT_NUM; o++) begin
        // A grant and a returned credit in the same cycle cancel out.
        case ({w_out_vld[o], i_credit_ret[o]})
          2'b10:   r_credit[o] <= r_credit[o] - CRED_W'(1);
          2'b01: begin
            if (r_credit[o] != CRED_W'(CREDIT_MAX)) r_credit[o] <= r_credit[o] + CRED_W'(1);
          end
          default: ;
        endcase

        if (w_out_vld[o]) begin
          if (!r_lock[o]) begin
            r_rr_ptr[o] <= wrap_idx(w_out_src[o], 1);
            if (!i_req_tail[w_out_src[o]]) begin
              r_lock[o]  <= 1'b1;
              r_owner[o] <= w_out_src[o];
            end
          end else if (i_req_tail[w_out_src[o]]) begin
            r_lock[o] <= 1'b0;
          end
        end
      end
      if (w_err_any) r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_switch_allocator.sv
// Testbench for switch_allocator: directed scenarios followed by random
// traffic, all checked against a behavioural model of the allocator.
module tb_switch_allocator;

  localparam int N  = 5;
  localparam int PW = 3;
  localparam int CW = 3;
  localparam int CM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N*PW-1:0] req_dest;
  logic [N-1:0]  req_head;
  logic [N-1:0]  req_tail;
  logic [N-1:0]  credit_ret;
  logic [N-1:0]  grant;
  logic [N-1:0]  xbar_valid;
  logic [N*PW-1:0] xbar_sel;
  logic [N*CW-1:0] credit_cnt;
  logic          err;

  switch_allocator dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .i_req_dest(req_dest),
    .i_req_head(req_head), .i_req_tail(req_tail),
    .i_credit_ret(credit_ret),
    .o_grant(grant), .o_xbar_valid(xbar_valid), .o_xbar_sel(xbar_sel),
    .o_credit_cnt(credit_cnt), .o_err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state
  int m_lock [N];
  int m_owner[N];
  int m_rr   [N];
  int m_cred [N];
  bit m_err;

  // Model expectations for the current cycle
  int            e_win[N];
  logic [N-1:0]  e_grant;
  logic [N-1:0]  e_vld;
  logic [N*PW-1:0] e_sel;
  logic [N*CW-1:0] e_cred;

  logic [N-1:0]  last_grant;
  logic [N*PW-1:0] last_sel;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int dest_of(input int i);
    logic [PW-1:0] d;
    d = req_dest[i*PW +: PW];
    return int'(d);
  endfunction

  // Winner per output: locked -> owner if asking; free -> among head requesters
  // the one at the smallest forward distance from the pointer.
  task automatic model_eval();
    e_grant = '0; e_vld = '0; e_sel = '0; e_cred = '0;
    for (int o = 0; o < N; o++) begin
      int best_d;
      e_win[o] = -1;
      e_cred[o*CW +: CW] = CW'(m_cred[o]);
      if (rst || m_cred[o] == 0) continue;
      if (m_lock[o] != 0) begin
        if (req_valid[m_owner[o]] && dest_of(m_owner[o]) == o) e_win[o] = m_owner[o];
      end else begin
        best_d = N;
        for (int i = 0; i < N; i++) begin
          if (req_valid[i] && dest_of(i) == o && req_head[i]) begin
            int d;
            d = (i - m_rr[o] + N) % N;
            if (d < best_d) begin best_d = d; e_win[o] = i; end
          end
        end
      end
      if (e_win[o] >= 0) begin
        e_vld[o] = 1'b1;
        e_grant[e_win[o]] = 1'b1;
        e_sel[o*PW +: PW] = PW'(e_win[o]);
      end
    end
  endtask

  task automatic model_step();
    if (rst) begin
      for (int o = 0; o < N; o++) begin
        m_lock[o] = 0; m_owner[o] = 0; m_rr[o] = 0; m_cred[o] = CM;
      end
      m_err = 0;
      return;
    end
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && dest_of(i) >= N) m_err = 1;
      else if (req_valid[i] && !req_head[i] && m_lock[dest_of(i)] == 0) m_err = 1;
    end
    for (int o = 0; o < N; o++) begin
      if (e_vld[o]) begin
        int w;
        w = e_win[o];
        if (!credit_ret[o]) m_cred[o]--;
        if (m_lock[o] == 0) begin
          m_rr[o] = (w + 1) % N;
          if (!req_tail[w]) begin m_lock[o] = 1; m_owner[o] = w; end
        end else if (req_tail[w]) begin
          m_lock[o] = 0;
        end
      end else if (credit_ret[o]) begin
        if (m_cred[o] == CM) m_err = 1;
        else m_cred[o]++;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_eval();
    chk("grant",      32'(grant),      32'(e_grant));
    chk("xbar_valid", 32'(xbar_valid), 32'(e_vld));
    chk("xbar_sel",   32'(xbar_sel),   32'(e_sel));
    chk("credit_cnt", 32'(credit_cnt), 32'(e_cred));
    chk("err",        32'(err),        32'(m_err));
    last_grant = grant;
    last_sel   = xbar_sel;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clr();
    req_valid = '0; req_dest = '0; req_head = '0; req_tail = '0; credit_ret = '0;
  endtask

  task automatic setreq(input int i, input int d, input bit h, input bit t);
    req_valid[i] = 1'b1;
    req_dest[i*PW +: PW] = PW'(d);
    req_head[i] = h;
    req_tail[i] = t;
  endtask

  task automatic pulse_rst();
    rst = 1'b1; cycle(); rst = 1'b0;
  endtask

  initial begin
    clr();
    for (int o = 0; o < N; o++) begin
      m_lock[o] = 0; m_owner[o] = 0; m_rr[o] = 0; m_cred[o] = CM;
    end
    m_err = 0;
    rst = 1'b1;
    @(posedge clk); #1;
    cycle();
    rst = 1'b0;
    chk("rst_cred", 32'(credit_cnt), 32'(15'b100_100_100_100_100));
    chk("rst_err",  32'(err), 32'd0);

    // Single-flit packet 2 -> 3
    setreq(2, 3, 1, 1); cycle();
    chk("sf_grant", 32'(last_grant), 32'b00100);
    chk("sf_sel3",  32'(last_sel[9 +: 3]), 32'd2);
    chk("sf_cred3", 32'(credit_cnt[9 +: 3]), 32'd3);
    clr();

    // Three heads contend for output 1, credit returned every cycle
    credit_ret = 5'b00010;
    setreq(0, 1, 1, 0); setreq(1, 1, 1, 0); setreq(4, 1, 1, 0);
    cycle(); chk("rr_head0", 32'(last_grant), 32'b00001);
    setreq(0, 1, 0, 0); cycle(); chk("rr_body0", 32'(last_grant), 32'b00001);
    setreq(0, 1, 0, 1); cycle(); chk("rr_tail0", 32'(last_grant), 32'b00001);
    req_valid[0] = 1'b0; cycle(); chk("rr_head1", 32'(last_grant), 32'b00010);
    setreq(1, 1, 0, 1); cycle(); chk("rr_tail1", 32'(last_grant), 32'b00010);
    req_valid[1] = 1'b0; setreq(4, 1, 1, 1); cycle();
    chk("rr_head4", 32'(last_grant), 32'b10000);
    chk("rr_cred1", 32'(credit_cnt[3 +: 3]), 32'd4);
    clr();

    // Five-flit packet 3 -> 2 exhausts credits
    setreq(3, 2, 1, 0); cycle(); chk("cr_f1", 32'(last_grant), 32'b01000);
    setreq(3, 2, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cycle(); chk("cr_body", 32'(last_grant), 32'b01000);
    end
    chk("cr_zero", 32'(credit_cnt[6 +: 3]), 32'd0);
    setreq(3, 2, 0, 1); cycle(); chk("cr_stall", 32'(last_grant), 32'b00000);
    credit_ret = 5'b00100; cycle(); chk("cr_stall2", 32'(last_grant), 32'b00000);
    chk("cr_one", 32'(credit_cnt[6 +: 3]), 32'd1);
    credit_ret = '0; cycle(); chk("cr_f5", 32'(last_grant), 32'b01000);
    chk("cr_zero2", 32'(credit_cnt[6 +: 3]), 32'd0);
    clr();

    // Output 0: grant with return, then saturation
    setreq(0, 0, 1, 1); cycle(); cycle();
    chk("ov_cred2", 32'(credit_cnt[0 +: 3]), 32'd2);
    credit_ret = 5'b00001; cycle();
    chk("ov_gr_ret", 32'(last_grant), 32'b00001);
    chk("ov_cred2b", 32'(credit_cnt[0 +: 3]), 32'd2);
    req_valid = '0;
    cycle(); chk("ov_cred3", 32'(credit_cnt[0 +: 3]), 32'd3); chk("ov_err0", 32'(err), 32'd0);
    cycle(); chk("ov_cred4", 32'(credit_cnt[0 +: 3]), 32'd4); chk("ov_err0b", 32'(err), 32'd0);
    cycle(); chk("ov_sat",   32'(credit_cnt[0 +: 3]), 32'd4); chk("ov_err1", 32'(err), 32'd1);
    clr(); pulse_rst();

    // Body flit to a free output, then a bad destination
    setreq(3, 4, 0, 0); cycle();
    chk("bd_grant", 32'(last_grant), 32'd0); chk("bd_err", 32'(err), 32'd1);
    clr(); pulse_rst();
    chk("bd_err_clr", 32'(err), 32'd0);
    setreq(0, 5, 1, 1); cycle();
    chk("dst_grant", 32'(last_grant), 32'd0); chk("dst_err", 32'(err), 32'd1);
    clr(); pulse_rst();

    // Reset mid-packet drops the lock
    setreq(0, 1, 1, 0); cycle(); chk("mr_head", 32'(last_grant), 32'b00001);
    setreq(0, 1, 0, 0); rst = 1'b1; cycle(); rst = 1'b0;
    chk("mr_quiet", 32'(last_grant), 32'd0);
    chk("mr_cred",  32'(credit_cnt[3 +: 3]), 32'd4);
    clr(); setreq(4, 1, 1, 1); cycle();
    chk("mr_new", 32'(last_grant), 32'b10000);
    clr();

    // Random traffic
    for (int c = 0; c < 800; c++) begin
      rst = ($urandom_range(0, 79) == 0);
      for (int i = 0; i < N; i++) begin
        req_valid[i] = ($urandom_range(0, 3) != 0);
        req_dest[i*PW +: PW] = ($urandom_range(0, 39) == 0) ? PW'($urandom_range(5, 7))
                                                            : PW'($urandom_range(0, 4));
        req_head[i] = ($urandom_range(0, 2) != 0);
        req_tail[i] = $urandom_range(0, 1) != 0;
        credit_ret[i] = ($urandom_range(0, 2) == 0);
      end
      cycle();
    end
    rst = 1'b0;
    clr();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
